// File: rtl/sprite_compositor_if.sv
// Pixel stream, sprite controls and per-sprite ROM port of the sprite compositor.
// master: timing generator, sprite engine and ROMs; slave: the compositor.
interface sprite_compositor_if #(
  parameter int NUM_SPRITES = 4,
  parameter int AW          = 8
);
  logic                      frame_start;
  logic                      in_valid;
  logic                      in_hsync;
  logic                      in_vsync;
  logic [9:0]                h_cnt;
  logic [9:0]                v_cnt;
  logic [NUM_SPRITES*10-1:0] spr_x;
  logic [NUM_SPRITES*10-1:0] spr_y;
  logic [NUM_SPRITES-1:0]    spr_en;
  logic [NUM_SPRITES-1:0]    spr_mirror;
  logic [11:0]               bg_color;
  logic [NUM_SPRITES*AW-1:0] rom_addr;
  logic [NUM_SPRITES*12-1:0] rom_data;
  logic [11:0]               out_rgb;
  logic                      out_hsync;
  logic                      out_vsync;
  logic                      out_valid;

  modport master (
    output frame_start, in_valid, in_hsync, in_vsync, h_cnt, v_cnt,
           spr_x, spr_y, spr_en, spr_mirror, bg_color, rom_data,
    input  rom_addr, out_rgb, out_hsync, out_vsync, out_valid
  );

  modport slave (
    input  frame_start, in_valid, in_hsync, in_vsync, h_cnt, v_cnt,
           spr_x, spr_y, spr_en, spr_mirror, bg_color, rom_data,
    output rom_addr, out_rgb, out_hsync, out_vsync, out_valid
  );
endinterface

// File: rtl/sprite_compositor.sv
// Overlays NUM_SPRITES colour-keyed square sprites on a live background colour.
// Latency ROM_LATENCY+2 cycles on colour, sync and valid alike; one pixel per clock, no back-pressure.
module sprite_compositor #(
  parameter int          NUM_SPRITES = 4,
  parameter int          SPRITE_LEN  = 16,
  parameter int          ROM_LATENCY = 1,
  parameter logic [11:0] TRANSPARENT = 12'hCBE
) (
  input logic               clk,
  input logic               rst,
  sprite_compositor_if.slave px
);
  localparam int          LW    = $clog2(SPRITE_LEN);
  localparam int          AW    = 2 * LW;
  localparam logic [10:0] LEN11 = 11'(SPRITE_LEN);

  if (SPRITE_LEN < 2 || (SPRITE_LEN & (SPRITE_LEN - 1)) != 0) begin : g_len_chk
    $error("sprite_compositor: SPRITE_LEN must be a power of two");
  end
  if (ROM_LATENCY < 0 || ROM_LATENCY > 3) begin : g_lat_chk
    $error("sprite_compositor: ROM_LATENCY must be in 0..3");
  end

  // Controls only change on frame_start so a sprite never tears mid-frame.
  logic [NUM_SPRITES*10-1:0] sh_x, sh_y;
  logic [NUM_SPRITES-1:0]    sh_en, sh_mirror;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_x      <= '0;
      sh_y      <= '0;
      sh_en     <= '0;
      sh_mirror <= '0;
    end else if (px.frame_start) begin
      sh_x      <= px.spr_x;
      sh_y      <= px.spr_y;
      sh_en     <= px.spr_en;
      sh_mirror <= px.spr_mirror;
    end
  end

  logic [NUM_SPRITES-1:0]    hit_d;
  logic [NUM_SPRITES*AW-1:0] addr_d;

  for (genvar i = 0; i < NUM_SPRITES; i++) begin : g_spr
    logic [10:0]   dx, dy;
    logic [LW-1:0] col;

    assign dx = {1'b0, px.h_cnt} - {1'b0, sh_x[10*i +: 10]};
    assign dy = {1'b0, px.v_cnt} - {1'b0, sh_y[10*i +: 10]};
    assign hit_d[i] = sh_en[i] & px.in_valid
                    & (px.h_cnt >= sh_x[10*i +: 10]) & (px.v_cnt >= sh_y[10*i +: 10])
                    & (dx < LEN11) & (dy < LEN11);
    // Inside the sprite dx < SPRITE_LEN, so inverting its low bits gives SPRITE_LEN-1-dx.
    assign col = sh_mirror[i] ? ~dx[LW-1:0] : dx[LW-1:0];
    assign addr_d[AW*i +: AW] = hit_d[i] ? {dy[LW-1:0], col} : '0;
  end

  // Index 0 is the stage that issues the ROM address; index ROM_LATENCY lines up with rom_data.
  logic [NUM_SPRITES-1:0]    hit_q [ROM_LATENCY+1];
  logic                      vld_q [ROM_LATENCY+1];
  logic                      hs_q  [ROM_LATENCY+1];
  logic                      vs_q  [ROM_LATENCY+1];
  logic [NUM_SPRITES*AW-1:0] addr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
      for (int k = 0; k <= ROM_LATENCY; k++) begin
        hit_q[k] <= '0;
        vld_q[k] <= 1'b0;
        hs_q[k]  <= 1'b1;
        vs_q[k]  <= 1'b1;
      end
    end else begin
      addr_q   <= addr_d;
      hit_q[0] <= hit_d;
      vld_q[0] <= px.in_valid;
      hs_q[0]  <= px.in_hsync;
      vs_q[0]  <= px.in_vsync;
      for (int k = 1; k <= ROM_LATENCY; k++) begin
        hit_q[k] <= hit_q[k-1];
        vld_q[k] <= vld_q[k-1];
        hs_q[k]  <= hs_q[k-1];
        vs_q[k]  <= vs_q[k-1];
      end
    end
  end

  assign px.rom_addr = addr_q;

  // Walk from the bottom of the stack up so the lowest opaque channel wins.
  logic [11:0] rgb_d;
  always_comb begin
    rgb_d = px.bg_color;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (hit_q[ROM_LATENCY][i] && (px.rom_data[12*i +: 12] != TRANSPARENT)) begin
        rgb_d = px.rom_data[12*i +: 12];
      end
    end
    if (!vld_q[ROM_LATENCY]) begin
      rgb_d = '0;
    end
  end

  logic [11:0] rgb_q;
  logic        vld_o, hs_o, vs_o;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb_q <= '0;
      vld_o <= 1'b0;
      hs_o  <= 1'b1;
      vs_o  <= 1'b1;
    end else begin
      rgb_q <= rgb_d;
      vld_o <= vld_q[ROM_LATENCY];
      hs_o  <= hs_q[ROM_LATENCY];
      vs_o  <= vs_q[ROM_LATENCY];
    end
  end

  assign px.out_rgb   = rgb_q;
  assign px.out_valid = vld_o;
  assign px.out_hsync = hs_o;
  assign px.out_vsync = vs_o;
endmodule
